// File: rtl/fft8_sequencer.sv
// fft8_sequencer
// Sequencer for an in-place radix-2 decimation-in-time FFT. It buffers one N-point frame
// (written in bit-reversed order), drives a single external combinational butterfly unit
// once per cycle for LOG2N stages, fetches twiddles from an external ROM, and then streams
// the frequency bins out in natural order.
//
// Optional feature: define FFT_STAGE_SCALE_EN to arithmetic-shift each 16-bit half of the
// butterfly results right by one before writeback (overall 1/N scaling).
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   in_valid/in_ready    time-domain sample handshake, in_data in natural order
//   out_valid/out_ready  frequency-bin handshake, out_data with bin number out_index
//   bf_a, bf_b, bf_w     butterfly operands (bf_w is tw_data passed through)
//   bf_sum, bf_diff      butterfly results a+W*b and a-W*b
//   tw_addr, tw_data     twiddle ROM index k (W_N^k) and its data
//   busy                 high while computing or unloading
//   done                 one-cycle pulse on acceptance of the last output bin
module fft8_sequencer #(
    parameter int unsigned N     = 8,
    parameter int unsigned LOG2N = 3,
    parameter int unsigned DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [LOG2N-1:0] out_index,
    output logic [DW-1:0]    bf_a,
    output logic [DW-1:0]    bf_b,
    output logic [DW-1:0]    bf_w,
    input  logic [DW-1:0]    bf_sum,
    input  logic [DW-1:0]    bf_diff,
    output logic [LOG2N-2:0] tw_addr,
    input  logic [DW-1:0]    tw_data,
    output logic             busy,
    output logic             done
);

    localparam logic [LOG2N-2:0] LastBfly  = (LOG2N-1)'(N / 2 - 1);
    localparam logic [LOG2N-1:0] LastStage = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] LastIdx   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] One       = LOG2N'(1);

    typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] load_cnt_q, load_cnt_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [LOG2N-2:0] bfly_q, bfly_d;
    logic [LOG2N-1:0] idx_q, idx_d;

    // Frame buffer, deliberately not reset.
    logic [DW-1:0] mem [N];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = v[LOG2N-1-b];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] writeback(input logic [DW-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
        localparam int unsigned HW = DW / 2;
        // Each half shifted independently so the imaginary sign never leaks into the real half.
        return {v[DW-1], v[DW-1:HW+1], v[HW-1], v[HW-1:1]};
`else
        return v;
`endif
    endfunction

    // Butterfly addressing: half = 2^stage, k = j mod half,
    // top = (j / half) * 2 * half + k, bot = top + half, twiddle = k * N / (2 * half).
    logic [LOG2N-1:0] bfly_ext, mask, k_full, top_idx, bot_idx;
    logic [LOG2N-2:0] k_small;
    logic             in_compute;

    always_comb begin
        bfly_ext   = {1'b0, bfly_q};
        mask       = (One << stage_q) - One;
        k_full     = bfly_ext & mask;
        top_idx    = ((bfly_ext >> stage_q) << (stage_q + One)) | k_full;
        bot_idx    = top_idx | (One << stage_q);
        // k < half <= N/2, so the narrower copy is lossless.
        k_small    = (LOG2N-1)'(k_full);
        in_compute = (state_q == StCompute);

        bf_a    = in_compute ? mem[top_idx] : '0;
        bf_b    = in_compute ? mem[bot_idx] : '0;
        tw_addr = in_compute ? (k_small << (LastStage - stage_q)) : '0;
        bf_w    = tw_data;

        out_data  = (state_q == StUnload) ? mem[idx_q] : '0;
        out_index = idx_q;
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        stage_d    = stage_q;
        bfly_d     = bfly_q;
        idx_d      = idx_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_cnt_d = load_cnt_q + One;
                    if (load_cnt_q == LastIdx) begin
                        state_d = StCompute;
                    end
                end
            end
            StCompute: begin
                busy   = 1'b1;
                bfly_d = bfly_q + (LOG2N-1)'(1);
                if (bfly_q == LastBfly) begin
                    if (stage_q == LastStage) begin
                        stage_d = '0;
                        state_d = StUnload;
                    end else begin
                        stage_d = stage_q + One;
                    end
                end
            end
            StUnload: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    idx_d = idx_q + One;
                    if (idx_q == LastIdx) begin
                        done    = 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            stage_q    <= '0;
            bfly_q     <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            stage_q    <= stage_d;
            bfly_q     <= bfly_d;
            idx_q      <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StLoad && in_valid) begin
                mem[bitrev(load_cnt_q)] <= in_data;
            end else if (state_q == StCompute) begin
                mem[top_idx] <= writeback(bf_sum);
                mem[bot_idx] <= writeback(bf_diff);
            end
        end
    end

endmodule

// File: tb/tb_fft8_sequencer.sv
// tb_fft8_sequencer
// Self-checking bench for fft8_sequencer (N=8). Supplies a Q15 complex butterfly and a
// twiddle ROM, runs a table of frames (fixed impulses plus random frames whose results come
// from a textbook iterative FFT model), checks timing, twiddle order, operand pairing,
// backpressure and mid-compute reset. Honours FFT_STAGE_SCALE_EN when defined.
module tb_fft8_sequencer;

    typedef logic [7:0][31:0]      frame_t;
    typedef logic [2:0][7:0][31:0] stages_t;
    typedef struct {
        frame_t  x;
        frame_t  y;
        stages_t stg;
        int      stall_idx;
    } vec_t;

`ifdef FFT_STAGE_SCALE_EN
    localparam logic [31:0] ImpRe  = 32'h0008_0000;
    localparam logic [31:0] ImpNeg = 32'hFFF8_0000;
    localparam logic [31:0] ImpCx  = 32'h0008_FFF8;
`else
    localparam logic [31:0] ImpRe  = 32'h0040_0000;
    localparam logic [31:0] ImpNeg = 32'hFFC0_0000;
    localparam logic [31:0] ImpCx  = 32'h0040_FFC0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_index;
    logic [31:0] bf_a, bf_b, bf_w, bf_sum, bf_diff;
    logic [1:0]  tw_addr;
    logic [31:0] tw_data;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fft8_sequencer #(.N(8), .LOG2N(3), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .bf_a      (bf_a),
        .bf_b      (bf_b),
        .bf_w      (bf_w),
        .bf_sum    (bf_sum),
        .bf_diff   (bf_diff),
        .tw_addr   (tw_addr),
        .tw_data   (tw_data),
        .busy      (busy),
        .done      (done)
    );

    // W_8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8), Q15.
    function automatic logic [31:0] tw_rom(input logic [1:0] k);
        case (k)
            2'd0:    return 32'h7FFF_0000;
            2'd1:    return 32'h5A82_A57E;
            2'd2:    return 32'h0000_8001;
            default: return 32'hA57E_A57E;
        endcase
    endfunction

    function automatic logic [31:0] cmul(input logic [31:0] w, input logic [31:0] b);
        int wr, wi, br, bi, pr, pi;
        wr = int'($signed(w[31:16]));
        wi = int'($signed(w[15:0]));
        br = int'($signed(b[31:16]));
        bi = int'($signed(b[15:0]));
        pr = (wr * br - wi * bi) >>> 15;
        pi = (wr * bi + wi * br) >>> 15;
        return {pr[15:0], pi[15:0]};
    endfunction

    function automatic logic [31:0] add16(input logic [31:0] a, input logic [31:0] p);
        logic [15:0] r, i;
        r = a[31:16] + p[31:16];
        i = a[15:0] + p[15:0];
        return {r, i};
    endfunction

    function automatic logic [31:0] sub16(input logic [31:0] a, input logic [31:0] p);
        logic [15:0] r, i;
        r = a[31:16] - p[31:16];
        i = a[15:0] - p[15:0];
        return {r, i};
    endfunction

    function automatic logic [31:0] stage_scale(input logic [31:0] v);
`ifdef FFT_STAGE_SCALE_EN
        logic signed [15:0] r, i;
        r = $signed(v[31:16]) >>> 1;
        i = $signed(v[15:0]) >>> 1;
        return {r, i};
`else
        return v;
`endif
    endfunction

    logic [31:0] wb_prod;
    always_comb begin
        wb_prod = cmul(bf_w, bf_b);
        bf_sum  = add16(bf_a, wb_prod);
        bf_diff = sub16(bf_a, wb_prod);
    end
    assign tw_data = tw_rom(tw_addr);

    function automatic int bitrev3(input int i);
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
    endfunction

    // Textbook iterative radix-2 DIT FFT; stg[s] holds the array entering stage s.
    task automatic ref_fft(input frame_t x, output stages_t stg, output frame_t y);
        frame_t      a;
        logic [31:0] u, p;
        int          len;
        for (int i = 0; i < 8; i++) a[bitrev3(i)] = x[i];
        stg[0] = a;
        for (int s = 0; s < 3; s++) begin
            len = 2 << s;
            for (int base = 0; base < 8; base += len) begin
                for (int m = 0; m < len / 2; m++) begin
                    p = cmul(tw_rom(2'(m * (8 / len))), a[base + m + len / 2]);
                    u = a[base + m];
                    a[base + m]           = stage_scale(add16(u, p));
                    a[base + m + len / 2] = stage_scale(sub16(u, p));
                end
            end
            if (s < 2) stg[s + 1] = a;
        end
        y = a;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    int tw_exp [12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int top_tab [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int bot_tab [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};

    task automatic load_frame(input frame_t x);
        for (int i = 0; i < 8; i++) begin
            chk("in_ready_load", 32'(in_ready), 32'd1);
            chk("out_valid_load", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = x[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic run_frame(input vec_t v);
        int idx, stalls, ncyc;
        load_frame(v.x);
        // COMPUTE occupies exactly 12 cycles; junk in_valid must be ignored.
        for (int c = 0; c < 12; c++) begin
            chk("in_ready_comp", 32'(in_ready), 32'd0);
            chk("out_valid_comp", 32'(out_valid), 32'd0);
            chk("busy_comp", 32'(busy), 32'd1);
            chk("tw_addr", 32'(tw_addr), 32'(tw_exp[c]));
            chk("bf_a_pair", bf_a, v.stg[c / 4][top_tab[c]]);
            chk("bf_b_pair", bf_b, v.stg[c / 4][bot_tab[c]]);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom();
            @(posedge clk); #1;
        end
        idx    = 0;
        stalls = 0;
        ncyc   = 8 + ((v.stall_idx >= 0) ? 5 : 0);
        for (int c = 0; c < ncyc; c++) begin
            if (idx == v.stall_idx && stalls < 5) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom();
            #1;
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("in_ready_unl", 32'(in_ready), 32'd0);
            chk("busy_unl", 32'(busy), 32'd1);
            chk("out_index", 32'(out_index), 32'(idx));
            chk("out_data", out_data, v.y[idx[2:0]]);
            chk("done", 32'(done), 32'(out_ready && idx == 7));
            @(posedge clk); #1;
            if (out_ready) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("out_valid_after", 32'(out_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
    endtask

    vec_t   vecs [10];
    frame_t fdummy;

    initial begin
        // Fixed frames with hand-derived results.
        for (int v = 0; v < 4; v++) begin
            vecs[v].x         = '0;
            vecs[v].stall_idx = -1;
        end
        vecs[0].x[0] = 32'h0040_0000;
        for (int i = 0; i < 8; i++) vecs[0].y[i] = ImpRe;
        vecs[1].x[0] = 32'hFFC0_0000;
        for (int i = 0; i < 8; i++) vecs[1].y[i] = ImpNeg;
        vecs[1].stall_idx = 3;
        vecs[2].x[0] = 32'h0040_FFC0;
        for (int i = 0; i < 8; i++) vecs[2].y[i] = ImpCx;
        vecs[3].y = '0;
        for (int v = 0; v < 4; v++) ref_fft(vecs[v].x, vecs[v].stg, fdummy);
        // Random frames, results from the model.
        for (int v = 4; v < 10; v++) begin
            for (int i = 0; i < 8; i++) vecs[v].x[i] = $urandom();
            vecs[v].stall_idx = (v % 2 == 0) ? int'($urandom_range(0, 7)) : -1;
            ref_fft(vecs[v].x, vecs[v].stg, vecs[v].y);
        end
        vecs[9].stall_idx = 7;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tw_addr", 32'(tw_addr), 32'd0);
        chk("rst_bf_a", bf_a, 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);

        for (int v = 0; v < 10; v++) run_frame(vecs[v]);

        // Reset asserted during the 6th COMPUTE cycle aborts the frame.
        load_frame(vecs[5].x);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_tw_addr", 32'(tw_addr), 32'd0);
        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
